// File: rtl/ex_stage.sv
// Execute stage of the 5-stage PCPU: operand forwarding, ALU, branch/jump resolution
// and an iterative shift-add multiplier. Define EX_FORWARD_EN to enable forwarding.
module ex_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1,
  parameter bit SLT_SIGNED         = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] regdata1_in,
  input  logic [31:0] regdata2_in,
  input  logic [31:0] ext_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] pc_add4_in,
  input  logic [25:0] addr_jump_in,
  input  logic [2:0]  ALUOP_in,
  input  logic        ALUSrc_in,
  input  logic        RegDst_in,
  input  logic        Branch_in,
  input  logic        JUMPSrc_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic        exmem_RegWrite,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_data,
  input  logic [31:0] memwb_data,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  wreg_out,
  output logic        MemWrite_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_target_out,
  output logic        jump_out,
  output logic [31:0] jump_target_out,
  output logic        stall_out,
  output logic [1:0]  fsm_state
);

  localparam int         N    = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [5:0] LAST = 6'(N - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  if (MUL_BITS_PER_CYCLE != 1 && MUL_BITS_PER_CYCLE != 2 && MUL_BITS_PER_CYCLE != 4) begin : g_bad_param
    $error("ex_stage: MUL_BITS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  mul_state_e  state;
  logic [5:0]  count;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [31:0] partial;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu;
  logic        slt;
  logic        mul_stall;

  always_comb begin
    fwd_a = regdata1_in;
    fwd_b = regdata2_in;
`ifdef EX_FORWARD_EN
    // EX_MEM is the younger producer, so it wins over MEM_WB.
    if (exmem_RegWrite && exmem_rd == rs_in && rs_in != 5'd0)
      fwd_a = exmem_data;
    else if (memwb_RegWrite && memwb_rd == rs_in && rs_in != 5'd0)
      fwd_a = memwb_data;
    if (exmem_RegWrite && exmem_rd == rt_in && rt_in != 5'd0)
      fwd_b = exmem_data;
    else if (memwb_RegWrite && memwb_rd == rt_in && rt_in != 5'd0)
      fwd_b = memwb_data;
`endif
  end

`ifndef EX_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{exmem_RegWrite, memwb_RegWrite, exmem_rd, memwb_rd,
                        exmem_data, memwb_data, rs_in};
`endif

  assign op_a = fwd_a;
  assign op_b = ALUSrc_in ? ext_in : fwd_b;

  assign slt = SLT_SIGNED ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

  always_comb begin
    case (ALUOP_in)
      OP_ADD:  alu = op_a + op_b;
      OP_SUB:  alu = op_a - op_b;
      OP_AND:  alu = op_a & op_b;
      OP_OR:   alu = op_a | op_b;
      OP_SLT:  alu = {31'd0, slt};
      OP_XOR:  alu = op_a ^ op_b;
      OP_NOR:  alu = ~(op_a | op_b);
      default: alu = 32'd0;
    endcase
  end

  // Partial product for the multiplier bits retired this cycle.
  always_comb begin
    partial = 32'd0;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++)
      if (mplier[j]) partial = partial + (mcand << j);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 6'd0;
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ALUOP_in == OP_MUL) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= 32'd0;
            count  <= 6'd0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc + partial;
          mcand  <= mcand << MUL_BITS_PER_CYCLE;
          mplier <= mplier >> MUL_BITS_PER_CYCLE;
          count  <= count + 6'd1;
          if (count == LAST) state <= DONE;
        end
        // DONE always returns to IDLE; a still-asserted MUL starts fresh from there.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // stall_out=1 freezes PC/IF_ID/ID_EX; the instruction in EX is accepted by EX_MEM
  // only on a cycle with stall_out=0, so all side-effect controls are bubbled while it is 1.
  assign mul_stall = (state == BUSY) || (state == IDLE && ALUOP_in == OP_MUL);

  always_comb begin
    alu_result_out    = 32'd0;
    store_data_out    = 32'd0;
    wreg_out          = 5'd0;
    MemWrite_out      = 1'b0;
    MemtoReg_out      = 1'b0;
    RegWrite_out      = 1'b0;
    branch_taken_out  = 1'b0;
    branch_target_out = 32'd0;
    jump_out          = 1'b0;
    jump_target_out   = 32'd0;
    stall_out         = 1'b0;
    fsm_state         = 2'd0;
    if (!rst) begin
      fsm_state         = state;
      stall_out         = mul_stall;
      if (state == DONE)
        alu_result_out = acc;
      else if (ALUOP_in != OP_MUL)
        alu_result_out = alu;
      store_data_out    = fwd_b;
      wreg_out          = RegDst_in ? rd_in : rt_in;
      branch_target_out = pc_add4_in + (ext_in << 2);
      jump_target_out   = {pc_add4_in[31:28], addr_jump_in, 2'b00};
      if (!mul_stall) begin
        MemWrite_out     = MemWrite_in;
        MemtoReg_out     = MemtoReg_in;
        RegWrite_out     = RegWrite_in;
        branch_taken_out = Branch_in && (fwd_a == fwd_b);
        jump_out         = JUMPSrc_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed and randomized ALU/forwarding/branch cases plus
// multiplier timing, back-to-back issue and mid-multiply reset.
module tb_ex_stage;

  localparam int MBPC  = 1;
  localparam int N     = 32 / MBPC;
  localparam bit SLT_S = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] regdata1_in, regdata2_in, ext_in, pc_add4_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic [25:0] addr_jump_in;
  logic [2:0]  ALUOP_in;
  logic        ALUSrc_in, RegDst_in, Branch_in, JUMPSrc_in;
  logic        MemWrite_in, MemtoReg_in, RegWrite_in;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic [31:0] alu_result_out, store_data_out, branch_target_out, jump_target_out;
  logic [4:0]  wreg_out;
  logic        MemWrite_out, MemtoReg_out, RegWrite_out;
  logic        branch_taken_out, jump_out, stall_out;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  ex_stage #(.MUL_BITS_PER_CYCLE(MBPC), .SLT_SIGNED(SLT_S)) dut (
    .clk(clk), .rst(rst),
    .regdata1_in(regdata1_in), .regdata2_in(regdata2_in), .ext_in(ext_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .pc_add4_in(pc_add4_in), .addr_jump_in(addr_jump_in), .ALUOP_in(ALUOP_in),
    .ALUSrc_in(ALUSrc_in), .RegDst_in(RegDst_in), .Branch_in(Branch_in), .JUMPSrc_in(JUMPSrc_in),
    .MemWrite_in(MemWrite_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .exmem_RegWrite(exmem_RegWrite), .memwb_RegWrite(memwb_RegWrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_data(exmem_data), .memwb_data(memwb_data),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .wreg_out(wreg_out),
    .MemWrite_out(MemWrite_out), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
    .jump_out(jump_out), .jump_target_out(jump_target_out), .stall_out(stall_out),
    .fsm_state(fsm_state)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] raw);
`ifdef EX_FORWARD_EN
    if (exmem_RegWrite && r != 5'd0 && exmem_rd == r) return exmem_data;
    if (memwb_RegWrite && r != 5'd0 && memwb_rd == r) return memwb_data;
`endif
    return raw;
  endfunction

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    sa = SLT_S ? longint'($signed(a)) : longint'(a);
    sb = SLT_S ? longint'($signed(b)) : longint'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd5:    return a ^ b;
      3'd6:    return ~(a | b);
      default: return 32'(64'(a) * 64'(b));
    endcase
  endfunction

  // Driver tasks
  task automatic set_idle();
    regdata1_in = 32'd0; regdata2_in = 32'd0; ext_in = 32'd0; pc_add4_in = 32'd0;
    rs_in = 5'd0; rt_in = 5'd0; rd_in = 5'd0; addr_jump_in = 26'd0; ALUOP_in = 3'd0;
    ALUSrc_in = 1'b0; RegDst_in = 1'b0; Branch_in = 1'b0; JUMPSrc_in = 1'b0;
    MemWrite_in = 1'b0; MemtoReg_in = 1'b0; RegWrite_in = 1'b0;
    exmem_RegWrite = 1'b0; memwb_RegWrite = 1'b0; exmem_rd = 5'd0; memwb_rd = 5'd0;
    exmem_data = 32'd0; memwb_data = 32'd0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    int   stall_cnt = 0;
    int   leak      = 0;
    bit   done      = 1'b0;
    logic [31:0] exp;
    cycle();
    set_idle();
    ALUOP_in = 3'b111; regdata1_in = a; regdata2_in = b;
    rs_in = 5'($urandom_range(1, 31)); rt_in = 5'($urandom_range(1, 31)); rd_in = 5'd9;
    RegDst_in = 1'b1; RegWrite_in = 1'b1; MemWrite_in = 1'b1; MemtoReg_in = 1'b1;
    Branch_in = 1'b1; JUMPSrc_in = 1'b1;
    exp_q.push_back(32'(64'(a) * 64'(b)));
    for (int c = 0; c < N + 8 && !done; c++) begin
      @(negedge clk);
      if (stall_out) begin
        stall_cnt++;
        if (RegWrite_out | MemWrite_out | MemtoReg_out | branch_taken_out | jump_out) leak++;
        cycle();
        // Forwarding sources move on while busy; the captured operands must not.
        exmem_RegWrite = 1'b1; exmem_rd = rs_in; exmem_data = $urandom;
        memwb_RegWrite = 1'b1; memwb_rd = rt_in; memwb_data = $urandom;
      end else begin
        done = 1'b1;
        exp  = exp_q.pop_front();
        total++;
        if (alu_result_out !== exp) begin
          bad++;
          $display("FAIL mul_result %h*%h: got %h want %h", a, b, alu_result_out, exp);
        end
        total++;
        if ({RegWrite_out, MemWrite_out, MemtoReg_out, jump_out} !== 4'b1111) begin
          bad++;
          $display("FAIL mul_done_ctrl: got %b want 1111",
                   {RegWrite_out, MemWrite_out, MemtoReg_out, jump_out});
        end
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL mul_timeout: stall still high after %0d cycles", N + 8);
    end
    total++;
    if (stall_cnt != N + 1) begin
      bad++;
      $display("FAIL mul_stall_cycles: got %0d want %0d", stall_cnt, N + 1);
    end
    total++;
    if (leak != 0) begin
      bad++;
      $display("FAIL mul_ctrl_leak: got %0d cycles with controls set want 0", leak);
    end
  endtask

  task automatic check_idle_add(input string tag);
    cycle();
    set_idle();
    regdata1_in = 32'd20; regdata2_in = 32'd25;
    @(negedge clk);
    total++;
    if (stall_out !== 1'b0 || alu_result_out !== 32'd45) begin
      bad++;
      $display("FAIL %s: got stall=%b alu=%h want stall=0 alu=0000002d", tag, stall_out,
               alu_result_out);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    regdata1_in = 32'h1234; regdata2_in = 32'h55; ALUOP_in = 3'b111; RegWrite_in = 1'b1;
    JUMPSrc_in = 1'b1; pc_add4_in = 32'hF000_0000; ext_in = 32'd3; RegDst_in = 1'b1; rd_in = 5'd7;
    cycle();
    cycle();
    @(negedge clk);
    total++;
    if ({alu_result_out, store_data_out, wreg_out, MemWrite_out, MemtoReg_out, RegWrite_out,
         branch_taken_out, branch_target_out, jump_out, jump_target_out, stall_out,
         fsm_state} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got alu=%h sd=%h tgt=%h jt=%h stall=%b want all 0",
               alu_result_out, store_data_out, branch_target_out, jump_target_out, stall_out);
    end
    cycle();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    total++;
    if (stall_out !== 1'b0 || fsm_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_release: got stall=%b state=%0d want 0/0", stall_out, fsm_state);
    end
  endtask

  task automatic test_add();
    cycle();
    set_idle();
    regdata1_in = 32'd5; regdata2_in = 32'd7; rs_in = 5'd1; rt_in = 5'd4; rd_in = 5'd9;
    RegDst_in = 1'b1; RegWrite_in = 1'b1;
    @(negedge clk);
    total++;
    if (alu_result_out !== 32'd12 || wreg_out !== 5'd9 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL add_regdst1: got alu=%h wreg=%0d stall=%b want 0000000c/9/0",
               alu_result_out, wreg_out, stall_out);
    end
    cycle();
    RegDst_in = 1'b0;
    @(negedge clk);
    total++;
    if (wreg_out !== 5'd4 || RegWrite_out !== 1'b1) begin
      bad++;
      $display("FAIL add_regdst0: got wreg=%0d rw=%b want 4/1", wreg_out, RegWrite_out);
    end
  endtask

  task automatic test_forward();
    logic [31:0] want;
    cycle();
    set_idle();
    regdata1_in = 32'd55; rs_in = 5'd3; ALUSrc_in = 1'b1; ext_in = 32'd0;
    exmem_RegWrite = 1'b1; exmem_rd = 5'd3; exmem_data = 32'd100;
    memwb_RegWrite = 1'b1; memwb_rd = 5'd3; memwb_data = 32'd200;
`ifdef EX_FORWARD_EN
    want = 32'd100;
`else
    want = 32'd55;
`endif
    @(negedge clk);
    total++;
    if (alu_result_out !== want) begin
      bad++;
      $display("FAIL fwd_priority: got %h want %h", alu_result_out, want);
    end
    cycle();
    exmem_rd = 5'd4;
`ifdef EX_FORWARD_EN
    want = 32'd200;
`else
    want = 32'd55;
`endif
    @(negedge clk);
    total++;
    if (alu_result_out !== want) begin
      bad++;
      $display("FAIL fwd_memwb: got %h want %h", alu_result_out, want);
    end
    cycle();
    rs_in = 5'd0; exmem_rd = 5'd0; memwb_rd = 5'd0;
    @(negedge clk);
    total++;
    if (alu_result_out !== 32'd55) begin
      bad++;
      $display("FAIL fwd_r0: got %h want 00000037", alu_result_out);
    end
  endtask

  task automatic test_branch_jump();
    cycle();
    set_idle();
    regdata1_in = 32'hABCD; regdata2_in = 32'hABCD; rs_in = 5'd1; rt_in = 5'd2;
    Branch_in = 1'b1; ALUOP_in = 3'd1; pc_add4_in = 32'h100; ext_in = 32'hFFFF_FFFF;
    ALUSrc_in = 1'b1;
    @(negedge clk);
    total++;
    if (branch_taken_out !== 1'b1 || branch_target_out !== 32'hFC) begin
      bad++;
      $display("FAIL beq_taken: got taken=%b tgt=%h want 1/000000fc", branch_taken_out,
               branch_target_out);
    end
    cycle();
    regdata2_in = 32'hABCE;
    @(negedge clk);
    total++;
    if (branch_taken_out !== 1'b0) begin
      bad++;
      $display("FAIL beq_not_taken: got %b want 0", branch_taken_out);
    end
    cycle();
    set_idle();
    JUMPSrc_in = 1'b1; addr_jump_in = 26'h40; pc_add4_in = 32'h104;
    @(negedge clk);
    total++;
    if (jump_out !== 1'b1 || jump_target_out !== 32'h100) begin
      bad++;
      $display("FAIL jump: got j=%b tgt=%h want 1/00000100", jump_out, jump_target_out);
    end
  endtask

  task automatic test_random_alu();
    logic [31:0] a, rt_val, b, e_alu, e_tgt, e_jt;
    logic        e_br;
    for (int i = 0; i < 40; i++) begin
      cycle();
      ALUOP_in = 3'($urandom_range(0, 6));
      rs_in = 5'($urandom_range(0, 3)); rt_in = 5'($urandom_range(0, 3)); rd_in = 5'($urandom);
      regdata1_in = $urandom;
      regdata2_in = ($urandom_range(0, 3) == 0) ? regdata1_in : $urandom;
      ext_in = $urandom; pc_add4_in = $urandom; addr_jump_in = 26'($urandom);
      ALUSrc_in = 1'($urandom); RegDst_in = 1'($urandom); Branch_in = 1'($urandom);
      JUMPSrc_in = 1'($urandom); MemWrite_in = 1'($urandom); MemtoReg_in = 1'($urandom);
      RegWrite_in = 1'($urandom);
      exmem_RegWrite = 1'($urandom); memwb_RegWrite = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      exmem_data = $urandom; memwb_data = $urandom;
      @(negedge clk);
      a      = m_fwd(rs_in, regdata1_in);
      rt_val = m_fwd(rt_in, regdata2_in);
      b      = ALUSrc_in ? ext_in : rt_val;
      e_alu  = m_alu(ALUOP_in, a, b);
      e_br   = Branch_in && (a == rt_val);
      e_tgt  = 32'(pc_add4_in + ext_in * 4);
      e_jt   = {pc_add4_in[31:28], 28'd0} + {4'd0, addr_jump_in, 2'd0};
      total++;
      if (alu_result_out !== e_alu) begin
        bad++;
        $display("FAIL rnd_alu op=%0d: got %h want %h", ALUOP_in, alu_result_out, e_alu);
      end
      total++;
      if (store_data_out !== rt_val || wreg_out !== (RegDst_in ? rd_in : rt_in)) begin
        bad++;
        $display("FAIL rnd_store_wreg: got %h/%0d want %h/%0d", store_data_out, wreg_out,
                 rt_val, RegDst_in ? rd_in : rt_in);
      end
      total++;
      if (branch_taken_out !== e_br || branch_target_out !== e_tgt || jump_target_out !== e_jt
          || jump_out !== JUMPSrc_in) begin
        bad++;
        $display("FAIL rnd_branch: got %b/%h/%b/%h want %b/%h/%b/%h", branch_taken_out,
                 branch_target_out, jump_out, jump_target_out, e_br, e_tgt, JUMPSrc_in, e_jt);
      end
      total++;
      if ({MemWrite_out, MemtoReg_out, RegWrite_out, stall_out} !==
          {MemWrite_in, MemtoReg_in, RegWrite_in, 1'b0}) begin
        bad++;
        $display("FAIL rnd_ctrl: got %b want %b",
                 {MemWrite_out, MemtoReg_out, RegWrite_out, stall_out},
                 {MemWrite_in, MemtoReg_in, RegWrite_in, 1'b0});
      end
    end
  endtask

  task automatic test_mul_single();
    run_mul(32'd7, 32'd6);
    check_idle_add("mul_no_restart");
    run_mul(32'hFFFF_FFFF, 32'd2);
    check_idle_add("mul_edge_idle");
    for (int i = 0; i < 3; i++) run_mul($urandom, $urandom);
    check_idle_add("mul_rand_idle");
  endtask

  task automatic test_back_to_back();
    run_mul(32'h0001_0003, 32'h0000_0101);
    run_mul(32'h8000_0001, 32'h0000_0003);
    check_idle_add("b2b_idle");
  endtask

  task automatic test_rst_mid_mul();
    cycle();
    set_idle();
    ALUOP_in = 3'b111; regdata1_in = 32'd123; regdata2_in = 32'd456; RegWrite_in = 1'b1;
    JUMPSrc_in = 1'b1; pc_add4_in = 32'h40; rd_in = 5'd3; RegDst_in = 1'b1;
    repeat (10) cycle();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({alu_result_out, store_data_out, wreg_out, MemWrite_out, MemtoReg_out, RegWrite_out,
         branch_taken_out, branch_target_out, jump_out, jump_target_out, stall_out,
         fsm_state} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got alu=%h tgt=%h wreg=%0d stall=%b want all 0",
               alu_result_out, branch_target_out, wreg_out, stall_out);
    end
    cycle();
    rst = 1'b0;
    set_idle();
    regdata1_in = 32'd3; regdata2_in = 32'd4;
    @(negedge clk);
    total++;
    if (stall_out !== 1'b0 || alu_result_out !== 32'd7 || fsm_state !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid_abort: got stall=%b alu=%h state=%0d want 0/00000007/0",
               stall_out, alu_result_out, fsm_state);
    end
    run_mul(32'd9, 32'd11);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_add();
    test_forward();
    test_branch_jump();
    test_random_alu();
    test_mul_single();
    test_back_to_back();
    test_rst_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
